lcd_cmd_seq: RTL
================

Name: lcd_cmd_seq

Overview:
- Upstream command sequencer for the 8x8 LCD image controller.
- Fetches a command script from a synchronous command ROM and issues one 4-bit command at a time on the controller's cmd/cmd_valid port.
- Before each issue it waits for the controller to become idle (busy low). After each issue it tracks the busy acknowledge and completion.
- Reports progress and completion to the testbench or top-level.

Parameters:
- ADDR_W, 6, command ROM address width; script holds at most 2^ADDR_W entries.
- ACK_TO, 8, cycles allowed after cmd_valid for busy to rise before the command is flagged unacknowledged.
- DONE_TO, 1024, watchdog limit in WAIT_DONE (used only with WATCHDOG_EN).

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  reset, synchronous, active-high
- start  in  1  one-cycle pulse, begin script at address 0
- cq_rd  out  1  command ROM read enable
- cq_addr  out  ADDR_W  command ROM address
- cq_data  in  5  ROM word, valid 1 cycle after cq_rd; [4]=end marker, [3:0]=command code
- cmd  out  4  command to LCD controller
- cmd_valid  out  1  one-cycle command strobe
- busy  in  1  LCD controller busy
- issued_cnt  out  ADDR_W+1  number of commands issued this run
- seq_busy  out  1  high from accepted start until FINISH
- seq_done  out  1  high in FINISH until next start or reset
- bad_cmd  out  1  sticky: reserved code (4'hC..4'hF) encountered
- err  out  1  sticky: ack timeout or watchdog expiry

Behaviour:
- Reset values:
  - all outputs 0
  - state IDLE
  - internal address pointer 0
  - ack and watchdog counters 0
- Reset mid-run aborts immediately; no cmd_valid is emitted in the reset cycle or the cycle after.
- IDLE:
  - start=1 -> clear issued_cnt, bad_cmd, err, pointer.
  - seq_busy<=1 -> FETCH.
- FETCH: cq_rd=1, cq_addr=pointer for exactly 1 cycle -> LATCH.
- LATCH: register cq_data. Then:
  - bit4=1 -> FINISH; the end word itself is not issued.
  - code in 4'hC..4'hF -> bad_cmd<=1, pointer+1, back to FETCH; the code is not issued.
  - otherwise -> WAIT_READY.
- WAIT_READY: stay while busy=1. This covers the controller's initial image load, during which busy is high after its reset. When busy=0 -> ISSUE.
- ISSUE:
  - cmd<=code, cmd_valid<=1 for exactly one cycle.
  - issued_cnt+1, ack counter cleared -> WAIT_ACK.
  - cmd holds its value until the next ISSUE.
- WAIT_ACK:
  - busy=1 -> WAIT_DONE.
  - ack counter reaching ACK_TO -> err<=1, pointer+1 -> FETCH; the command is not reissued.
- WAIT_DONE: busy=0 -> pointer+1 -> FETCH.
- Pointer wrap: if pointer = 2^ADDR_W-1 when incremented, go to FINISH instead of FETCH. Reaching the last entry without an end marker ends the run.
- FINISH: seq_busy<=0, seq_done<=1. A start pulse here restarts as from IDLE, and seq_done clears on the same edge.
- start while seq_busy=1 is ignored.
- issued_cnt saturates at its maximum value.
- Latency: end-of-previous-command (busy low) to next cmd_valid is at least 3 cycles (FETCH, LATCH, ISSUE). WAIT_READY adds none if busy is already low.

Optional Feature:
- LCD_CMD_SEQ_WATCHDOG_EN defined:
  - Counter runs in WAIT_DONE.
  - Reaching DONE_TO cycles with busy still high -> err<=1 -> FINISH (run aborted).
  - Counter clears on every entry to WAIT_DONE.
- Not defined: no counter is instantiated, and WAIT_DONE waits indefinitely.

Test Plan:
- Script {1,4,0,end} with the controller model holding busy high 70 cycles after reset:
  - The first cmd_valid appears only after busy falls.
  - cmd sequence is 1,4,0, with one cmd_valid each.
  - issued_cnt=3, seq_done=1, err=0, bad_cmd=0.
- Script {7,D,0,end}:
  - Issues 7 then 0.
  - bad_cmd=1, issued_cnt=2.
  - No cmd_valid is ever driven with code 4'hD.
- Model never raises busy after a cmd_valid:
  - err=1 exactly ACK_TO cycles after the strobe.
  - The sequencer proceeds to the next entry.
  - No duplicate strobe for the same entry.
- With LCD_CMD_SEQ_WATCHDOG_EN, model holds busy high forever after the ack:
  - err=1 and seq_done=1 after DONE_TO cycles.
  - Remaining entries not issued.
- Full 64-entry script with no end marker, all code 0:
  - 64 strobes issued.
  - issued_cnt=64, then FINISH; no re-fetch of address 0.
- Reset asserted for 1 cycle while in WAIT_DONE, then start:
  - All outputs return to 0.
  - The run restarts from address 0.
  - issued_cnt counts from 0.

Source files
------------

// File: rtl/lcd_cmd_seq.sv
`default_nettype none
// ============================================================================
//  Module   : lcd_cmd_seq
//  Purpose  : Upstream command sequencer for the 8x8 LCD image controller.
//             It fetches a command script from a synchronous ROM and issues
//             one 4-bit command at a time. Before each issue it waits for
//             busy to go low, then tracks the busy acknowledge and the
//             command's completion.
//  Options  : LCD_CMD_SEQ_WATCHDOG_EN - abort the run if busy stays high in
//             WAIT_DONE for DONE_TO cycles.
//  Revision : 1.0 - initial release
// ============================================================================
module lcd_cmd_seq #(
    parameter int ADDR_W  = 6,
    parameter int ACK_TO  = 8,     // must be >= 2
    parameter int DONE_TO = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              cq_rd,
    output logic [ADDR_W-1:0] cq_addr,
    input  logic [4:0]        cq_data,
    output logic [3:0]        cmd,
    output logic              cmd_valid,
    input  logic              busy,
    output logic [ADDR_W:0]   issued_cnt,
    output logic              seq_busy,
    output logic              seq_done,
    output logic              bad_cmd,
    output logic              err
);

    localparam logic [2:0] c_S_IDLE       = 3'd0;
    localparam logic [2:0] c_S_FETCH      = 3'd1;
    localparam logic [2:0] c_S_LATCH      = 3'd2;
    localparam logic [2:0] c_S_WAIT_READY = 3'd3;
    localparam logic [2:0] c_S_ISSUE      = 3'd4;
    localparam logic [2:0] c_S_WAIT_ACK   = 3'd5;
    localparam logic [2:0] c_S_WAIT_DONE  = 3'd6;
    localparam logic [2:0] c_S_FINISH     = 3'd7;

    localparam int c_ACK_W = $clog2(ACK_TO + 1);

    logic [2:0]        r_state;
    logic [2:0]        w_next;
    logic [ADDR_W-1:0] r_ptr;
    logic [3:0]        r_code;
    logic [3:0]        r_cmd;
    logic              r_cmd_valid;
    logic [ADDR_W:0]   r_issued;
    logic              r_seq_busy;
    logic              r_seq_done;
    logic              r_bad;
    logic              r_err;
    logic [c_ACK_W-1:0] r_ack_cnt;

    logic w_start_run;
    logic w_ptr_inc;
    logic w_set_bad;
    logic w_set_err;
    logic w_last;
    logic w_ack_hit;

    // The last ROM entry ends the run instead of wrapping back to address 0.
    assign w_last = (r_ptr == {ADDR_W{1'b1}});

    // WAIT_ACK cycle k after the strobe holds count k-1; firing at ACK_TO-2
    // makes err visible exactly ACK_TO cycles after the strobe cycle.
    assign w_ack_hit = (r_ack_cnt == c_ACK_W'(ACK_TO - 2));

`ifdef LCD_CMD_SEQ_WATCHDOG_EN
    localparam int c_WD_W = $clog2(DONE_TO + 1);

    logic [c_WD_W-1:0] r_wd_cnt;
    logic              w_wd_hit;

    assign w_wd_hit = (r_wd_cnt == c_WD_W'(DONE_TO - 1));

    // Watchdog counts WAIT_DONE cycles; it is zero on every entry.
    always_ff @(posedge clk) begin
        if (reset || (r_state != c_S_WAIT_DONE)) begin
            r_wd_cnt <= '0;
        end else begin
            r_wd_cnt <= r_wd_cnt + 1'b1;
        end
    end
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic and per-cycle control strobes.
    always_comb begin
        w_next      = r_state;
        w_start_run = 1'b0;
        w_ptr_inc   = 1'b0;
        w_set_bad   = 1'b0;
        w_set_err   = 1'b0;
        case (r_state)
            c_S_IDLE, c_S_FINISH: begin
                if (start) begin
                    w_start_run = 1'b1;
                    w_next      = c_S_FETCH;
                end
            end
            c_S_FETCH: begin
                w_next = c_S_LATCH;
            end
            c_S_LATCH: begin
                if (cq_data[4]) begin
                    w_next = c_S_FINISH;
                end else if (cq_data[3:2] == 2'b11) begin
                    w_set_bad = 1'b1;
                    w_ptr_inc = 1'b1;
                    w_next    = w_last ? c_S_FINISH : c_S_FETCH;
                end else if (busy) begin
                    w_next = c_S_WAIT_READY;
                end else begin
                    // Controller already idle: no extra WAIT_READY cycle.
                    w_next = c_S_ISSUE;
                end
            end
            c_S_WAIT_READY: begin
                if (!busy) begin
                    w_next = c_S_ISSUE;
                end
            end
            c_S_ISSUE: begin
                w_next = c_S_WAIT_ACK;
            end
            c_S_WAIT_ACK: begin
                if (busy) begin
                    w_next = c_S_WAIT_DONE;
                end else if (w_ack_hit) begin
                    w_set_err = 1'b1;
                    w_ptr_inc = 1'b1;
                    w_next    = w_last ? c_S_FINISH : c_S_FETCH;
                end
            end
            c_S_WAIT_DONE: begin
`ifdef LCD_CMD_SEQ_WATCHDOG_EN
                if (busy && w_wd_hit) begin
                    w_set_err = 1'b1;
                    w_next    = c_S_FINISH;
                end else
`endif
                if (!busy) begin
                    w_ptr_inc = 1'b1;
                    w_next    = w_last ? c_S_FINISH : c_S_FETCH;
                end
            end
            default: begin
                w_next = c_S_IDLE;
            end
        endcase
    end

    // Script pointer: restart at 0, advance after each entry, never wrap.
    always_ff @(posedge clk) begin
        if (reset || w_start_run) begin
            r_ptr <= '0;
        end else if (w_ptr_inc && !w_last) begin
            r_ptr <= r_ptr + 1'b1;
        end
    end

    // Capture the ROM word's code in LATCH for use from WAIT_READY.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_code <= '0;
        end else if (r_state == c_S_LATCH) begin
            r_code <= cq_data[3:0];
        end
    end

    // Command strobe is high during the ISSUE cycle; cmd holds afterwards.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cmd       <= '0;
            r_cmd_valid <= 1'b0;
        end else begin
            r_cmd_valid <= (w_next == c_S_ISSUE);
            if (w_next == c_S_ISSUE) begin
                r_cmd <= (r_state == c_S_LATCH) ? cq_data[3:0] : r_code;
            end
        end
    end

    // Acknowledge timer: cleared in ISSUE, counts each WAIT_ACK cycle.
    always_ff @(posedge clk) begin
        if (reset || (r_state == c_S_ISSUE)) begin
            r_ack_cnt <= '0;
        end else if (r_state == c_S_WAIT_ACK) begin
            r_ack_cnt <= r_ack_cnt + 1'b1;
        end
    end

    // Issued-command counter, saturating.
    always_ff @(posedge clk) begin
        if (reset || w_start_run) begin
            r_issued <= '0;
        end else if ((r_state == c_S_ISSUE) && (r_issued != {(ADDR_W+1){1'b1}})) begin
            r_issued <= r_issued + 1'b1;
        end
    end

    // Run status and sticky error flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_seq_busy <= 1'b0;
            r_seq_done <= 1'b0;
            r_bad      <= 1'b0;
            r_err      <= 1'b0;
        end else if (w_start_run) begin
            r_seq_busy <= 1'b1;
            r_seq_done <= 1'b0;
            r_bad      <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            if (w_next == c_S_FINISH) begin
                r_seq_busy <= 1'b0;
                r_seq_done <= 1'b1;
            end
            if (w_set_bad) begin
                r_bad <= 1'b1;
            end
            if (w_set_err) begin
                r_err <= 1'b1;
            end
        end
    end

    assign cq_rd      = (r_state == c_S_FETCH);
    assign cq_addr    = r_ptr;
    assign cmd        = r_cmd;
    assign cmd_valid  = r_cmd_valid;
    assign issued_cnt = r_issued;
    assign seq_busy   = r_seq_busy;
    assign seq_done   = r_seq_done;
    assign bad_cmd    = r_bad;
    assign err        = r_err;

endmodule
`default_nettype wire
